program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, is the instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0, is the byte address of the first instruction written.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a new load from DONE or ERROR.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-009 memWrite  output  1  instruction memory write strobe, one cycle per word.
REQ-010 memAddr  output  32  byte address of the write, word-aligned, same addressing as the PC.
REQ-011 memData  output  32  assembled instruction word.
REQ-012 programLoaded  output  1  high while a complete program is in memory.
REQ-013 loadError  output  1  high after a rejected length header.

Function
REQ-014 The stream SHALL be: 2-byte word count N (big-endian), then N words of 4 bytes each, most significant byte first.
REQ-015 The FSM SHALL have four states: LEN_HI, LEN_LO, DATA, DONE, plus ERROR.
REQ-016 byte_ready SHALL be 1 in LEN_HI, LEN_LO and DATA, and 0 in DONE and ERROR.
REQ-017 LEN_HI goes to LEN_LO on a transfer.
REQ-018 LEN_LO, on a transfer, goes to DONE if N=0, to ERROR if N>MAX_WORDS, and to DATA otherwise.
REQ-019 In DATA, bytes SHALL be shifted into a 32-bit assembly register.
REQ-020 On the 4th byte of a word, memWrite=1 SHALL be asserted in the next cycle with the full word on memData.
REQ-021 The first word SHALL be written at memAddr=BASE_ADDR; memAddr SHALL increment by 4 per word, 32-bit wrap.
REQ-022 The byte transfer that completes word N SHALL move the FSM to DONE; programLoaded=1 SHALL be asserted in the same cycle as the final memWrite.
REQ-023 A zero-length load SHALL reach DONE with programLoaded=1 and no memWrite.
REQ-024 In ERROR, loadError=1, programLoaded=0 and no memWrite SHALL occur.
REQ-025 When start=1 in DONE or ERROR, the loader SHALL go to LEN_HI next cycle and clear programLoaded, loadError, the byte counter and memAddr (to BASE_ADDR).
REQ-026 start SHALL be ignored in LEN_HI, LEN_LO and DATA.
REQ-027 byte_valid in the same cycle as start SHALL NOT be accepted, because byte_ready=0 in that cycle.
REQ-028 Idle cycles (byte_valid=0) SHALL stall without changing state or the partial word.
REQ-029 memData and memAddr SHALL be held stable while memWrite=0.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately set: state LEN_HI, byte_ready=1 once released, memWrite=0, memAddr=BASE_ADDR, memData=0, programLoaded=0, loadError=0, counters=0.
REQ-031 Reset mid-load SHALL discard the partial word; no memWrite SHALL occur until a new header and full word are received.

Structure
REQ-032 The FSM state encoding and the MAX_WORDS default SHALL live in a shared package used by the fetch stage and the loader.
REQ-033 Byte-to-word assembly (shift register plus 2-bit byte count) SHALL be one sub-module, word_assembler.

Verification
REQ-034 Header 00 02, bytes 20 08 00 05 8C 09 00 04 -> memWrite at 0x0 data 0x20080005, then at 0x4 data 0x8C090004; programLoaded=1 with the second write.
REQ-035 Header 00 00 -> DONE, programLoaded=1, zero memWrite pulses.
REQ-036 Header 01 01 with MAX_WORDS=256 -> loadError=1, byte_ready=0, no writes; start pulse -> LEN_HI, loadError=0.
REQ-037 N=1 with byte_valid gaps of 3 cycles between bytes -> single write of the correct word; no premature strobe.
REQ-038 reset_n low after 2 data bytes, then header 00 01 and AA BB CC DD -> one write of 0xAABBCCDD at 0x0.
REQ-039 In DONE, start and byte_valid both high in one cycle -> byte not consumed; the next byte is taken as LEN_HI.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the fetch stage:
// loader FSM state encoding and the default instruction memory capacity.
package program_loader_pkg;

    localparam int unsigned DEFAULT_MAX_WORDS = 256;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERROR
    } loaderState_t;

endpackage

// File: rtl/word_assembler.sv
// Shifts serial bytes (MSB first) into a 32-bit instruction word and
// flags the transfer that completes each word.
module word_assembler (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        shiftEn,
    input  logic [7:0]  byteIn,
    output logic        wordComplete,
    output logic [31:0] wordOut
);

    logic [23:0] shiftReg;
    logic [1:0]  byteCount;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shiftReg  <= '0;
            byteCount <= '0;
        end else if (clear) begin
            shiftReg  <= '0;
            byteCount <= '0;
        end else if (shiftEn) begin
            shiftReg  <= {shiftReg[15:0], byteIn};
            byteCount <= byteCount + 2'd1;
        end
    end

    // Only the first three bytes are stored; the fourth is taken straight
    // from the input so the word is complete on the accepting transfer.
    assign wordComplete = shiftEn && (byteCount == 2'd3);
    assign wordOut      = {shiftReg, byteIn};

endmodule

// File: rtl/program_loader.sv
// Serial program loader: 16-bit big-endian word count, then N 32-bit words
// written sequentially to instruction memory starting at BASE_ADDR.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memData,
    output logic        programLoaded,
    output logic        loadError
);

    loaderState_t state;
    logic [7:0]   lenHi;
    logic [15:0]  lenWords;
    logic [15:0]  wordCount;
    logic [31:0]  nextAddr;
    logic         take;
    logic         restart;
    logic         wordComplete;
    logic [31:0]  wordOut;

    assign byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign take       = byte_valid && byte_ready;
    assign restart    = start && ((state == DONE) || (state == ERROR));

    word_assembler assembler (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (restart),
        .shiftEn      (take && (state == DATA)),
        .byteIn       (byte_in),
        .wordComplete (wordComplete),
        .wordOut      (wordOut)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= LEN_HI;
            lenHi         <= '0;
            lenWords      <= '0;
            wordCount     <= '0;
            nextAddr      <= BASE_ADDR;
            memWrite      <= 1'b0;
            memAddr       <= BASE_ADDR;
            memData       <= '0;
            programLoaded <= 1'b0;
            loadError     <= 1'b0;
        end else begin
            memWrite <= 1'b0;
            case (state)
                LEN_HI: begin
                    if (take) begin
                        lenHi <= byte_in;
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        lenWords <= {lenHi, byte_in};
                        if ({lenHi, byte_in} == 16'd0) begin
                            state         <= DONE;
                            programLoaded <= 1'b1;
                        end else if (32'({lenHi, byte_in}) > MAX_WORDS) begin
                            state     <= ERROR;
                            loadError <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // memAddr/memData only move with the strobe, so they stay
                    // stable between writes; nextAddr tracks the upcoming slot.
                    if (wordComplete) begin
                        memWrite  <= 1'b1;
                        memData   <= wordOut;
                        memAddr   <= nextAddr;
                        nextAddr  <= nextAddr + 32'd4;
                        wordCount <= wordCount + 16'd1;
                        if (wordCount + 16'd1 == lenWords) begin
                            state         <= DONE;
                            programLoaded <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        state         <= LEN_HI;
                        programLoaded <= 1'b0;
                        loadError     <= 1'b0;
                        wordCount     <= '0;
                        memAddr       <= BASE_ADDR;
                        nextAddr      <= BASE_ADDR;
                    end
                end
                default: state <= LEN_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus process and checked by an independent monitor on each strobe.
module tb_program_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        loaded;
    } wrExp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        programLoaded;
    logic        loadError;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned writesSeen = 0;
    wrExp_t      expQ[$];

    program_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .memWrite      (memWrite),
        .memAddr       (memAddr),
        .memData       (memData),
        .programLoaded (programLoaded),
        .loadError     (loadError)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n && memWrite) begin
            wrExp_t e;
            writesSeen++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", memAddr, memData);
            end else begin
                e = expQ.pop_front();
                if (memAddr !== e.addr || memData !== e.data || programLoaded !== e.loaded) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h loaded=%b want addr=%h data=%h loaded=%b",
                             memAddr, memData, programLoaded, e.addr, e.data, e.loaded);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] a, input logic [31:0] d, input logic l);
        wrExp_t e;
        e.addr = a; e.data = d; e.loaded = l;
        expQ.push_back(e);
    endtask

    // Caller is always just after a rising edge.
    task automatic sendByte(input logic [7:0] b, input int unsigned gap);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clock);
        chk("ready_before_byte", 32'(byte_ready), 32'd1);
        @(posedge clock); #1;
        byte_valid = 1'b0;
        for (int unsigned i = 0; i < gap; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic chkDrained(input string name);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending writes want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        int unsigned w0;
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned wBefore;

        // Reset state
        #12;
        chk("rst_memWrite", 32'(memWrite), 32'd0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_memData", memData, 32'h0);
        chk("rst_loaded", 32'(programLoaded), 32'd0);
        chk("rst_error", 32'(loadError), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("rst_ready", 32'(byte_ready), 32'd1);

        // Two-word program
        pushExp(32'h0, 32'h20080005, 1'b0);
        pushExp(32'h4, 32'h8C090004, 1'b1);
        sendByte(8'h00, 0); sendByte(8'h02, 0);
        sendByte(8'h20, 0); sendByte(8'h08, 0); sendByte(8'h00, 0); sendByte(8'h05, 0);
        sendByte(8'h8C, 0); sendByte(8'h09, 0); sendByte(8'h00, 0); sendByte(8'h04, 0);
        idle(3);
        chkDrained("two_word_writes");
        chk("two_word_loaded", 32'(programLoaded), 32'd1);
        chk("done_ready", 32'(byte_ready), 32'd0);
        chk("done_addr_held", memAddr, 32'h4);
        chk("done_data_held", memData, 32'h8C090004);

        // Zero-length program
        pulseStart();
        chk("start_clears_loaded", 32'(programLoaded), 32'd0);
        chk("start_clears_addr", memAddr, 32'h0);
        wBefore = writesSeen;
        sendByte(8'h00, 0); sendByte(8'h00, 0);
        idle(2);
        chk("zero_len_loaded", 32'(programLoaded), 32'd1);
        chk("zero_len_no_write", writesSeen, wBefore);

        // Oversize header rejected
        pulseStart();
        wBefore = writesSeen;
        sendByte(8'h01, 0); sendByte(8'h01, 0);
        idle(2);
        chk("err_flag", 32'(loadError), 32'd1);
        chk("err_ready", 32'(byte_ready), 32'd0);
        chk("err_loaded", 32'(programLoaded), 32'd0);
        chk("err_no_write", writesSeen, wBefore);
        pulseStart();
        chk("err_cleared", 32'(loadError), 32'd0);
        chk("err_restart_ready", 32'(byte_ready), 32'd1);

        // Single word with idle gaps
        sendByte(8'h00, 3); sendByte(8'h01, 3);
        pushExp(32'h0, 32'h12345678, 1'b1);
        sendByte(8'h12, 3); sendByte(8'h34, 3); sendByte(8'h56, 3);
        chk("gap_no_early_write", 32'(expQ.size()), 32'd1);
        sendByte(8'h78, 3);
        chkDrained("gap_write");

        // Reset mid-load discards the partial word
        pulseStart();
        sendByte(8'h00, 0); sendByte(8'h02, 0);
        sendByte(8'h11, 0); sendByte(8'h22, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_memData", memData, 32'h0);
        chk("midrst_memAddr", memAddr, 32'h0);
        chk("midrst_loaded", 32'(programLoaded), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        sendByte(8'h00, 0); sendByte(8'h01, 0);
        pushExp(32'h0, 32'hAABBCCDD, 1'b1);
        sendByte(8'hAA, 0); sendByte(8'hBB, 0); sendByte(8'hCC, 0); sendByte(8'hDD, 0);
        idle(2);
        chkDrained("midrst_write");

        // start with byte_valid in DONE: byte must not be consumed
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h00;
        @(negedge clock);
        chk("start_cycle_ready", 32'(byte_ready), 32'd0);
        @(posedge clock); #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        sendByte(8'h00, 0); sendByte(8'h01, 0);
        pushExp(32'h0, 32'h01020304, 1'b1);
        sendByte(8'h01, 0); sendByte(8'h02, 0); sendByte(8'h03, 0); sendByte(8'h04, 0);
        idle(2);
        chkDrained("start_valid_write");
        chk("start_valid_loaded", 32'(programLoaded), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
